// File: rtl/tape_arbiter.sv
// Tape RAM arbiter: shares the single RAM port between the core (priority) and a host port.
// Optional TAPE_CLEAR_EN macro adds a zero-fill sweep after reset or on clear_req.
module tape_arbiter #(
    parameter int ADDR_WIDTH        = 16,
    parameter int DATA_WIDTH        = 8,
    parameter int CLEAR_DEPTH       = 65536,
    parameter int HOST_STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_stall,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    input  logic                  clear_req,
    output logic                  clear_busy,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int SW = (HOST_STARVE_LIMIT > 0) ? $clog2(HOST_STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(HOST_STARVE_LIMIT);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_HOST} owner_t;

    state_t          state, state_nxt;
    owner_t          rd_owner, rd_owner_nxt;
    logic [SW-1:0]   starve_cnt, starve_nxt;
    logic            host_win, core_win;

`ifdef TAPE_CLEAR_EN
    localparam int CW = (CLEAR_DEPTH > 1) ? $clog2(CLEAR_DEPTH) : 1;
    logic [CW-1:0]   clr_cnt, clr_nxt;
`else
    logic            unused_clear;
    assign unused_clear = clear_req ^ (CLEAR_DEPTH == 0);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
`ifdef TAPE_CLEAR_EN
            state      <= ST_CLEAR;
            clr_cnt    <= '0;
`else
            state      <= ST_IDLE;
`endif
            starve_cnt <= '0;
            rd_owner   <= OWN_NONE;
        end else begin
            state      <= state_nxt;
`ifdef TAPE_CLEAR_EN
            clr_cnt    <= clr_nxt;
`endif
            starve_cnt <= starve_nxt;
            rd_owner   <= rd_owner_nxt;
        end
    end

    // Host only beats a requesting core once it has been denied HOST_STARVE_LIMIT cycles in a row.
    always_comb begin
        state_nxt    = state;
        starve_nxt   = starve_cnt;
        rd_owner_nxt = OWN_NONE;
        host_win     = 1'b0;
        core_win     = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = core_addr;
        ram_wdata    = core_wdata;
`ifdef TAPE_CLEAR_EN
        clr_nxt      = clr_cnt;
`endif
        if (state == ST_IDLE) begin
            host_win = host_req &&
                       (!core_req || ((HOST_STARVE_LIMIT > 0) && (starve_cnt == STARVE_MAX)));
            core_win = core_req && !host_win;
            if (host_win) begin
                ram_we    = host_we;
                ram_addr  = host_addr;
                ram_wdata = host_wdata;
                if (!host_we) rd_owner_nxt = OWN_HOST;
            end else if (core_win) begin
                ram_we    = core_we;
                if (!core_we) rd_owner_nxt = OWN_CORE;
            end
            if (host_req && !host_win) begin
                if (starve_cnt != STARVE_MAX) starve_nxt = starve_cnt + 1'b1;
            end else begin
                starve_nxt = '0;
            end
`ifdef TAPE_CLEAR_EN
            if (clear_req) state_nxt = ST_CLEAR;
`endif
        end
`ifdef TAPE_CLEAR_EN
        else begin
            ram_we    = 1'b1;
            ram_addr  = ADDR_WIDTH'(clr_cnt);
            ram_wdata = '0;
            if (clr_cnt == CW'(CLEAR_DEPTH - 1)) begin
                clr_nxt   = '0;
                state_nxt = ST_IDLE;
            end else begin
                clr_nxt   = clr_cnt + 1'b1;
            end
        end
`endif
    end

    assign host_gnt    = host_win;
    assign core_stall  = core_req && !core_win;
    assign host_rvalid = (rd_owner == OWN_HOST);
    assign core_rdata  = ram_rdata;
    assign host_rdata  = ram_rdata;
`ifdef TAPE_CLEAR_EN
    assign clear_busy  = (state == ST_CLEAR);
`else
    assign clear_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_tape_arbiter.sv
// Directed bench for tape_arbiter with a behavioural synchronous RAM attached to the ram_* port.
// Covers both builds of the TAPE_CLEAR_EN macro.
module tb_tape_arbiter;

    logic        clock;
    logic        reset_n;
    logic        core_req, core_we;
    logic [15:0] core_addr;
    logic [7:0]  core_wdata, core_rdata;
    logic        core_stall;
    logic        host_req, host_we;
    logic [15:0] host_addr;
    logic [7:0]  host_wdata, host_rdata;
    logic        host_gnt, host_rvalid;
    logic        clear_req, clear_busy;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;
    logic [7:0]  mem [0:65535];

    int tests_run = 0;
    int fail_count = 0;

    tape_arbiter #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8), .CLEAR_DEPTH(16), .HOST_STARVE_LIMIT(4)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .clear_req(clear_req), .clear_busy(clear_busy),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM: write commits at the edge, read data appears the following cycle.
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic c_req, input logic c_we, input logic [15:0] c_addr,
                                  input logic [7:0] c_wdata, input logic h_req, input logic h_we,
                                  input logic [15:0] h_addr, input logic [7:0] h_wdata);
        core_req   = c_req;
        core_we    = c_we;
        core_addr  = c_addr;
        core_wdata = c_wdata;
        host_req   = h_req;
        host_we    = h_we;
        host_addr  = h_addr;
        host_wdata = h_wdata;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        clear_req = 1'b0;
        apply_stimulus(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        repeat (2) tick();

`ifdef TAPE_CLEAR_EN
        apply_stimulus(1'b1, 1'b0, 16'h0033, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        check_output("rst_busy", clear_busy, 1);
        check_output("rst_ram_we", ram_we, 1);
        check_output("rst_ram_addr", ram_addr, 0);
        check_output("rst_stall", core_stall, 1);
        check_output("rst_rvalid", host_rvalid, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_output("sweep_we", ram_we, 1);
            check_output("sweep_addr", ram_addr, i);
            check_output("sweep_data", ram_wdata, 0);
            check_output("sweep_stall", core_stall, 1);
            check_output("sweep_busy", clear_busy, 1);
            tick();
        end
        check_output("sweep_done_busy", clear_busy, 0);
        check_output("sweep_done_stall", core_stall, 0);
        apply_stimulus(1'b1, 1'b1, 16'h0001, 8'h55, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
`else
        apply_stimulus(1'b1, 1'b1, 16'h0001, 8'h55, 1'b0, 1'b0, 16'h0, 8'h0);
        check_output("rst_busy", clear_busy, 0);
        check_output("rst_rvalid", host_rvalid, 0);
        check_output("rst_gnt", host_gnt, 0);
        reset_n = 1'b1;
        #1;
        check_output("first_we", ram_we, 1);
        check_output("first_addr", ram_addr, 16'h0001);
        check_output("first_data", ram_wdata, 8'h55);
        check_output("first_busy", clear_busy, 0);
        check_output("first_stall", core_stall, 0);
        tick();
`endif

        // Core write then read of the same cell on consecutive cycles.
        apply_stimulus(1'b1, 1'b1, 16'h0005, 8'h2A, 1'b0, 1'b0, 16'h0, 8'h0);
        check_output("cw_we", ram_we, 1);
        check_output("cw_addr", ram_addr, 16'h0005);
        check_output("cw_stall", core_stall, 0);
        tick();
        apply_stimulus(1'b1, 1'b0, 16'h0005, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0);
        check_output("cr_we", ram_we, 0);
        check_output("cr_stall", core_stall, 0);
        tick();
        apply_stimulus(1'b0, 1'b0, 16'h0007, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0);
        check_output("cr_rdata", core_rdata, 8'h2A);
        check_output("cr_no_hvalid", host_rvalid, 0);
        check_output("idle_we", ram_we, 0);
        check_output("idle_addr", ram_addr, 16'h0007);
        tick();

        // Host writes 0x7F to 0x0010, then reads it back.
        apply_stimulus(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0010, 8'h7F);
        check_output("hw_gnt", host_gnt, 1);
        check_output("hw_we", ram_we, 1);
        check_output("hw_addr", ram_addr, 16'h0010);
        check_output("hw_data", ram_wdata, 8'h7F);
        tick();
        check_output("hw_no_rvalid", host_rvalid, 0);
        apply_stimulus(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'h0010, 8'h00);
        check_output("hr_gnt", host_gnt, 1);
        check_output("hr_we", ram_we, 0);
        tick();
        apply_stimulus(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        check_output("hr_rvalid", host_rvalid, 1);
        check_output("hr_rdata", host_rdata, 8'h7F);
        tick();
        check_output("hr_rvalid_drop", host_rvalid, 0);

        // Contention: core keeps the port for 4 cycles, host forced in on the 5th.
        apply_stimulus(1'b1, 1'b0, 16'h0020, 8'h0, 1'b1, 1'b0, 16'h0010, 8'h0);
        for (int i = 0; i < 4; i++) begin
            check_output("starve_gnt", host_gnt, 0);
            check_output("starve_stall", core_stall, 0);
            check_output("starve_addr", ram_addr, 16'h0020);
            tick();
        end
        check_output("forced_gnt", host_gnt, 1);
        check_output("forced_stall", core_stall, 1);
        check_output("forced_addr", ram_addr, 16'h0010);
        tick();
        check_output("after_gnt", host_gnt, 0);
        check_output("after_stall", core_stall, 0);
        check_output("after_rvalid", host_rvalid, 1);
        check_output("after_rdata", host_rdata, 8'h7F);
        tick();

        // Dropping host_req clears the starvation count.
        apply_stimulus(1'b1, 1'b0, 16'h0020, 8'h0, 1'b0, 1'b0, 16'h0010, 8'h0);
        tick();
        apply_stimulus(1'b1, 1'b0, 16'h0020, 8'h0, 1'b1, 1'b0, 16'h0010, 8'h0);
        for (int i = 0; i < 4; i++) begin
            check_output("restarve_gnt", host_gnt, 0);
            tick();
        end
        check_output("restarve_forced", host_gnt, 1);
        tick();

`ifdef TAPE_CLEAR_EN
        // clear_req lets the current access finish, then a reset mid-sweep restarts it.
        apply_stimulus(1'b1, 1'b1, 16'h0005, 8'h2A, 1'b0, 1'b0, 16'h0, 8'h0);
        clear_req = 1'b1;
        #1;
        check_output("clrreq_we", ram_we, 1);
        check_output("clrreq_addr", ram_addr, 16'h0005);
        check_output("clrreq_stall", core_stall, 0);
        check_output("clrreq_busy", clear_busy, 0);
        tick();
        clear_req = 1'b0;
        apply_stimulus(1'b1, 1'b0, 16'h0005, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        for (int i = 0; i < 7; i++) begin
            check_output("resweep_addr", ram_addr, i);
            check_output("resweep_busy", clear_busy, 1);
            tick();
        end
        check_output("resweep_addr7", ram_addr, 7);
        reset_n = 1'b0;
        #1;
        check_output("midrst_addr", ram_addr, 0);
        check_output("midrst_busy", clear_busy, 1);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_output("restart_addr", ram_addr, i);
            check_output("restart_busy", clear_busy, 1);
            tick();
        end
        check_output("restart_done_busy", clear_busy, 0);
        check_output("restart_done_stall", core_stall, 0);
        tick();
        apply_stimulus(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        check_output("cleared_cell", core_rdata, 8'h00);
`else
        // Without the clear feature clear_req has no effect.
        apply_stimulus(1'b1, 1'b1, 16'h0003, 8'h11, 1'b0, 1'b0, 16'h0, 8'h0);
        clear_req = 1'b1;
        #1;
        check_output("clrreq_busy", clear_busy, 0);
        tick();
        clear_req = 1'b0;
        apply_stimulus(1'b1, 1'b1, 16'h0004, 8'h22, 1'b0, 1'b0, 16'h0, 8'h0);
        check_output("noclr_we", ram_we, 1);
        check_output("noclr_addr", ram_addr, 16'h0004);
        check_output("noclr_stall", core_stall, 0);
        check_output("noclr_busy", clear_busy, 0);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
